// File: rtl/dma_burst_packer.sv
// Feeds the DMA write FIFO in wr_aclk, keeping writes aligned to whole bursts.
// Partial bursts are padded with PAD_WORD on a flush request or an idle timeout.
module dma_burst_packer #(
    parameter int                    BURST_LEN     = 256,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD      = 32'hAAAA_AAAA,
    parameter int                    FLUSH_TIMEOUT = 4096
) (
    input  logic                  wr_aclk,
    input  logic                  wr_aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  flush_req,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] din_dma,
    output logic                  wr_en,
    output logic [31:0]           burst_count,
    output logic [31:0]           pad_count,
    output logic                  busy_pad
);

    localparam int WCW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam int ICW = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [WCW-1:0] LAST = WCW'(BURST_LEN - 1);
    localparam logic [ICW-1:0] TMO  = ICW'(FLUSH_TIMEOUT);

    typedef enum logic {PASS, PAD} state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [ICW-1:0] idle_cnt;
    logic [WCW-1:0] wc_inc;
    logic [WCW-1:0] wc_post;
    logic           accept;
    logic           timeout;

    assign s_ready  = wr_aresetn & (state == PASS) & ~fifo_full;
    assign busy_pad = (state == PAD);

    always_comb begin
        accept  = s_valid & s_ready;
        wc_inc  = word_cnt + 1'b1;
        wc_post = accept ? wc_inc : word_cnt;
        timeout = (idle_cnt == TMO);
    end

    always_ff @(posedge wr_aclk or negedge wr_aresetn) begin
        if (!wr_aresetn) begin
            state       <= PASS;
            word_cnt    <= '0;
            idle_cnt    <= '0;
            wr_en       <= 1'b0;
            din_dma     <= '0;
            burst_count <= '0;
            pad_count   <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                PASS: begin
                    if (accept) begin
                        wr_en    <= 1'b1;
                        din_dma  <= s_data;
                        word_cnt <= wc_inc;
                        if (word_cnt == LAST)
                            burst_count <= burst_count + 32'd1;
                    end
                    // idle time only matters while a burst is partly filled
                    if (accept || word_cnt == '0)
                        idle_cnt <= '0;
                    else if (!timeout)
                        idle_cnt <= idle_cnt + 1'b1;
                    if (wc_post != '0 && (flush_req || timeout))
                        state <= PAD;
                end
                PAD: begin
                    idle_cnt <= '0;
                    if (!fifo_full) begin
                        wr_en     <= 1'b1;
                        din_dma   <= PAD_WORD;
                        word_cnt  <= wc_inc;
                        pad_count <= pad_count + 32'd1;
                        if (word_cnt == LAST) begin
                            burst_count <= burst_count + 32'd1;
                            state       <= PASS;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_packer.sv
// Bench for dma_burst_packer: directed scenarios plus random traffic
// against a burst-fill model that tracks fill level and pad words owed.
module tb_dma_burst_packer;

    localparam int          BL  = 256;
    localparam int          TMO = 4096;
    localparam logic [31:0] PW  = 32'hAAAA_AAAA;

    logic        wr_aclk;
    logic        wr_aresetn;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        flush_req;
    logic        fifo_full;
    logic [31:0] din_dma;
    logic        wr_en;
    logic [31:0] burst_count;
    logic [31:0] pad_count;
    logic        busy_pad;

    int tests;
    int fails;

    dma_burst_packer #(
        .BURST_LEN(BL), .DATA_WIDTH(32),
        .PAD_WORD(PW), .FLUSH_TIMEOUT(TMO)
    ) dut (
        .wr_aclk(wr_aclk), .wr_aresetn(wr_aresetn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush_req(flush_req), .fifo_full(fifo_full),
        .din_dma(din_dma), .wr_en(wr_en),
        .burst_count(burst_count), .pad_count(pad_count),
        .busy_pad(busy_pad)
    );

    initial wr_aclk = 1'b0;
    always #5 wr_aclk = ~wr_aclk;

    // model: words in current burst, pad words still owed
    int          m_fill;
    int          m_pad_left;
    int          m_idle;
    int          m_old_idle;
    int unsigned m_bursts;
    int unsigned m_pads;
    bit          m_wr;
    logic [31:0] m_din;

    always @(posedge wr_aclk or negedge wr_aresetn) begin
        if (!wr_aresetn) begin
            m_fill = 0; m_pad_left = 0; m_idle = 0;
            m_bursts = 0; m_pads = 0; m_wr = 0; m_din = '0;
        end else begin
            m_wr = 0;
            if (m_pad_left == 0) begin
                m_old_idle = m_idle;
                if (s_valid && !fifo_full) begin
                    m_wr = 1; m_din = s_data; m_idle = 0;
                    m_fill = m_fill + 1;
                    if (m_fill == BL) begin
                        m_fill = 0; m_bursts++;
                    end
                end else if (m_fill == 0) begin
                    m_idle = 0;
                end else if (m_idle < TMO) begin
                    m_idle++;
                end
                if (m_fill != 0 && (flush_req || m_old_idle == TMO))
                    m_pad_left = BL - m_fill;
            end else if (!fifo_full) begin
                m_wr = 1; m_din = PW; m_pads++;
                m_fill++; m_pad_left--;
                if (m_pad_left == 0) begin
                    m_fill = 0; m_bursts++; m_idle = 0;
                end
            end
        end
    end

    logic sr_seen;
    bit   sr_exp;

    task automatic step(input bit v, input logic [31:0] d,
                        input bit fl, input bit ff);
        s_valid = v; s_data = d; flush_req = fl; fifo_full = ff;
        #1;
        sr_seen = s_ready;
        sr_exp  = wr_aresetn && m_pad_left == 0 && !ff;
        @(posedge wr_aclk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 0; s_data = '0; flush_req = 0; fifo_full = 0;
        #2 wr_aresetn = 1'b0;
        repeat (2) @(posedge wr_aclk);
        #1 wr_aresetn = 1'b1;
    endtask

    task automatic test_reset();
        s_valid = 1; s_data = 32'h1234; flush_req = 0; fifo_full = 0;
        wr_aresetn = 1'b1;
        #1 wr_aresetn = 1'b0;
        #1;
        tests++;
        if (s_ready !== 1'b0) begin
            fails++; $display("FAIL rst_sready: got %b want 0", s_ready);
        end
        repeat (2) @(posedge wr_aclk);
        #1;
        tests++;
        if (wr_en !== 1'b0 || din_dma !== 32'h0 || busy_pad !== 1'b0) begin
            fails++;
            $display("FAIL rst_out: wr %b din %h busy %b want 0 0 0",
                     wr_en, din_dma, busy_pad);
        end
        tests++;
        if (burst_count !== 32'h0 || pad_count !== 32'h0) begin
            fails++;
            $display("FAIL rst_cnt: bc %0d pc %0d want 0 0",
                     burst_count, pad_count);
        end
        s_valid = 0;
        wr_aresetn = 1'b1;
    endtask

    task automatic test_full_burst();
        int bad = 0;
        int nwr = 0;
        int nbusy = 0;
        do_reset();
        for (int i = 0; i < BL; i++) begin
            step(1, i, 0, 0);
            if (wr_en === 1'b1) nwr++;
            if (busy_pad !== 1'b0) nbusy++;
            if (wr_en !== 1'b1 || din_dma !== 32'(i)) bad++;
        end
        tests++;
        if (bad != 0 || nwr != BL) begin
            fails++;
            $display("FAIL full_data: bad %0d writes %0d want 0 %0d",
                     bad, nwr, BL);
        end
        tests++;
        if (burst_count !== 32'd1 || pad_count !== 32'd0 || nbusy != 0) begin
            fails++;
            $display("FAIL full_cnt: bc %0d pc %0d busy %0d want 1 0 0",
                     burst_count, pad_count, nbusy);
        end
    endtask

    task automatic test_flush();
        int pads = 0;
        int low = 0;
        bit got = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 32'h100 + i, 0, 0);
        step(0, 0, 1, 0);
        tests++;
        if (busy_pad !== 1'b1) begin
            fails++; $display("FAIL flush_busy: got %b want 1", busy_pad);
        end
        for (int k = 0; k < 400 && !got; k++) begin
            step(1, 32'h0B0B_0011, 0, 0);
            if (!sr_seen) low++;
            if (wr_en === 1'b1 && din_dma === PW) pads++;
            if (wr_en === 1'b1 && din_dma === 32'h0B0B_0011) got = 1;
        end
        tests++;
        if (!got || pads != 246 || low != 246) begin
            fails++;
            $display("FAIL flush_pad: got %b pads %0d low %0d want 1 246 246",
                     got, pads, low);
        end
        tests++;
        if (pad_count !== 32'd246 || burst_count !== 32'd1) begin
            fails++;
            $display("FAIL flush_cnt: pc %0d bc %0d want 246 1",
                     pad_count, burst_count);
        end
        for (int i = 1; i < BL; i++) step(1, i, 0, 0);
        tests++;
        if (burst_count !== 32'd2 || pad_count !== 32'd246) begin
            fails++;
            $display("FAIL flush_next: bc %0d pc %0d want 2 246",
                     burst_count, pad_count);
        end
    endtask

    task automatic test_timeout();
        int first_busy = 0;
        int first_pad = 0;
        int pads = 0;
        int nwr = 0;
        int nbusy = 0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, i, 0, 0);
        for (int k = 1; k < TMO + 400; k++) begin
            step(0, 0, 0, 0);
            if (busy_pad === 1'b1 && first_busy == 0) first_busy = k;
            if (wr_en === 1'b1 && din_dma === PW) begin
                pads++;
                if (first_pad == 0) first_pad = k;
            end
            if (first_busy != 0 && busy_pad !== 1'b1) break;
        end
        tests++;
        if (first_busy != TMO + 1 || first_pad != TMO + 2) begin
            fails++;
            $display("FAIL tmo_lat: busy %0d pad %0d want %0d %0d",
                     first_busy, first_pad, TMO + 1, TMO + 2);
        end
        tests++;
        if (pads != 253 || burst_count !== 32'd1 || pad_count !== 32'd253) begin
            fails++;
            $display("FAIL tmo_pad: pads %0d bc %0d pc %0d want 253 1 253",
                     pads, burst_count, pad_count);
        end
        for (int k = 0; k < 10000; k++) begin
            step(0, 0, 0, 0);
            if (wr_en !== 1'b0) nwr++;
            if (busy_pad !== 1'b0) nbusy++;
        end
        tests++;
        if (nwr != 0 || nbusy != 0) begin
            fails++;
            $display("FAIL tmo_idle0: writes %0d busy %0d want 0 0",
                     nwr, nbusy);
        end
    endtask

    task automatic test_backpressure();
        int pads = 0;
        int viol = 0;
        bit ff;
        do_reset();
        for (int i = 0; i < 100; i++) step(1, i, 0, 0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 1000; k++) begin
            ff = ((k / 4) % 2) == 1;
            step(0, 0, 0, ff);
            if (ff && wr_en !== 1'b0) viol++;
            if (wr_en === 1'b1 && din_dma === PW) pads++;
            if (busy_pad !== 1'b1) break;
        end
        tests++;
        if (viol != 0 || pads != 156) begin
            fails++;
            $display("FAIL bp_pad: viol %0d pads %0d want 0 156", viol, pads);
        end
        tests++;
        if (pad_count !== 32'd156 || burst_count !== 32'd1) begin
            fails++;
            $display("FAIL bp_cnt: pc %0d bc %0d want 156 1",
                     pad_count, burst_count);
        end
    endtask

    task automatic test_simultaneous();
        int nwr = 0;
        int nbusy = 0;
        do_reset();
        for (int i = 0; i < BL - 1; i++) step(1, i, 0, 0);
        step(1, BL - 1, 1, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0);
            if (wr_en !== 1'b0) nwr++;
            if (busy_pad !== 1'b0) nbusy++;
        end
        tests++;
        if (nwr != 0 || nbusy != 0 || burst_count !== 32'd1
            || pad_count !== 32'd0) begin
            fails++;
            $display("FAIL sim_last: wr %0d busy %0d bc %0d pc %0d want 0 0 1 0",
                     nwr, nbusy, burst_count, pad_count);
        end
        step(0, 0, 1, 0);
        step(1, 32'h77, 0, 0);
        nwr = 0; nbusy = 0;
        if (wr_en === 1'b1) nwr++;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0);
            if (wr_en === 1'b1) nwr++;
            if (busy_pad !== 1'b0) nbusy++;
        end
        tests++;
        if (nwr != 1 || nbusy != 0 || pad_count !== 32'd0) begin
            fails++;
            $display("FAIL sim_idle_flush: wr %0d busy %0d pc %0d want 1 0 0",
                     nwr, nbusy, pad_count);
        end
    endtask

    task automatic test_reset_mid_pad();
        int pads = 0;
        int bad = 0;
        int nbusy = 0;
        do_reset();
        for (int i = 0; i < 20; i++) step(1, i, 0, 0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 100 && pads < 50; k++) begin
            step(0, 0, 0, 0);
            if (wr_en === 1'b1 && din_dma === PW) pads++;
        end
        s_valid = 1; fifo_full = 0;
        #2 wr_aresetn = 1'b0;
        #1;
        tests++;
        if (pads != 50 || wr_en !== 1'b0 || din_dma !== 32'h0
            || busy_pad !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: pads %0d wr %b din %h busy %b sr %b want 50 0 0 0 0",
                     pads, wr_en, din_dma, busy_pad, s_ready);
        end
        tests++;
        if (burst_count !== 32'h0 || pad_count !== 32'h0) begin
            fails++;
            $display("FAIL mid_rst_cnt: bc %0d pc %0d want 0 0",
                     burst_count, pad_count);
        end
        repeat (2) @(posedge wr_aclk);
        #1 wr_aresetn = 1'b1;
        for (int i = 0; i < BL; i++) begin
            step(1, 32'h5000 + i, 0, 0);
            if (wr_en !== 1'b1 || din_dma !== 32'h5000 + 32'(i)) bad++;
            if (busy_pad !== 1'b0) nbusy++;
        end
        tests++;
        if (bad != 0 || nbusy != 0 || burst_count !== 32'd1
            || pad_count !== 32'd0) begin
            fails++;
            $display("FAIL mid_rst_burst: bad %0d busy %0d bc %0d pc %0d want 0 0 1 0",
                     bad, nbusy, burst_count, pad_count);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        bit v, fl, ff;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            v  = $urandom_range(0, 3) != 0;
            ff = $urandom_range(0, 3) == 0;
            fl = $urandom_range(0, 49) == 0;
            step(v, $urandom, fl, ff);
            tests++;
            if (sr_seen !== sr_exp || wr_en !== m_wr
                || (m_wr && din_dma !== m_din)
                || busy_pad !== (m_pad_left != 0)
                || burst_count !== m_bursts || pad_count !== m_pads) begin
                fails++; bad++;
                if (bad < 20)
                    $display("FAIL rand_cyc %0d: sr %b/%b wr %b/%b din %h/%h bc %0d/%0d pc %0d/%0d",
                             k, sr_seen, sr_exp, wr_en, m_wr, din_dma, m_din,
                             burst_count, m_bursts, pad_count, m_pads);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_full_burst();
        test_flush();
        test_timeout();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_pad();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_burst_packer.md
# dma_burst_packer

Upstream feeder for the DMA write FIFO, running in the `wr_aclk` domain.
- Accepts a 32-bit data word stream with a valid/ready handshake and forwards it as `din_dma`/`wr_en` writes into the DMA FIFO.
- Tracks position within the current 256-word DMA burst.
- On flush request or idle timeout, pads any partial burst with a fill word so the downstream DMA master always sees complete bursts.

## Interface
- `BURST_LEN`, 256: words per DMA burst; power of two, 2..256.
- `DATA_WIDTH`, 32: word width.
- `PAD_WORD`, 32'hAAAA_AAAA: fill word written during padding.
- `FLUSH_TIMEOUT`, 4096: idle cycles with a partial burst before automatic padding; ≥2.
- `wr_aclk`  in  1  clock; all logic is in this domain.
- `wr_aresetn`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_WIDTH  source word.
- `s_valid`  in  1  source word valid.
- `s_ready`  out  1  block can accept `s_data` this cycle.
- `flush_req`  in  1  single-cycle pulse; pad the current partial burst.
- `fifo_full`  in  1  DMA FIFO prog_full; write back-pressure.
- `din_dma`  out  DATA_WIDTH  FIFO write data, registered.
- `wr_en`  out  1  FIFO write enable, registered.
- `burst_count`  out  32  completed bursts, including padded ones; wraps at 2^32.
- `pad_count`  out  32  total pad words written; wraps at 2^32.
- `busy_pad`  out  1  high while in the PAD state.

## Operation
- State machine with two states, PASS and PAD. Reset state is PASS.
- `word_cnt` is log2(BURST_LEN) bits (1 bit when BURST_LEN=2). It is the index of the next word within the current burst.
- `idle_cnt` is log2(FLUSH_TIMEOUT)+1 bits.

PASS state:
- `s_ready = ~fifo_full`.
- On accept (`s_valid & s_ready`), next cycle: `wr_en=1`, `din_dma=s_data`, `word_cnt` increments modulo BURST_LEN.
- When `word_cnt` wraps from BURST_LEN-1 to 0, `burst_count` increments.
- `idle_cnt` is cleared on an accept, or while `word_cnt==0`. Otherwise it increments, saturating at FLUSH_TIMEOUT.
- PASS→PAD when the post-accept `word_cnt` is non-zero and either `flush_req=1` this cycle or `idle_cnt` reaches FLUSH_TIMEOUT.
- `flush_req` with post-accept `word_cnt==0` is ignored, and is never remembered.

PAD state:
- `s_ready=0`. Source words are held off, never dropped.
- Each cycle with `fifo_full=0`, next cycle: `wr_en=1`, `din_dma=PAD_WORD`, `word_cnt` increments, `pad_count` increments.
- The write of index BURST_LEN-1 increments `burst_count` and returns the state to PASS, with `idle_cnt` cleared.
- `flush_req` in PAD is ignored.

Reset (async assert, any state including mid-pad):
- `wr_en=0`, `din_dma=0`, `word_cnt=0`, `idle_cnt=0`, `burst_count=0`, `pad_count=0`, `busy_pad=0`, state=PASS.
- `s_ready=0` while `wr_aresetn=0`.
- A partially padded burst is abandoned. The FIFO is reset by the same system reset.

## Timing
- Input-to-FIFO latency is 1 cycle: an accept at edge N gives `wr_en` high after edge N+1.
- `wr_en` is high for exactly one cycle per word. At most one word is written per cycle.
- `s_ready` is combinational from state and `fifo_full`. It has no combinational path from `s_valid`.
- Writes are gated only by `fifo_full` sampled in the accept/pad decision cycle. One write may land after `fifo_full` rises; the prog_full threshold carries ≥2 words of margin.
- Throughput is 1 word/cycle in both PASS and PAD when not back-pressured.
- Automatic padding: the last accept at edge N gives `busy_pad=1` after edge N+FLUSH_TIMEOUT+1. The first pad word is written one cycle later.
- Flush: `flush_req` at edge N gives `busy_pad=1` after edge N+1. Padding remaining R words with no back-pressure returns to PASS after R cycles; `s_ready` reasserts in that same cycle.
- `burst_count` and `pad_count` update in the same cycle as the corresponding `wr_en`.

## Test plan
- 256 consecutive words 0..255, `fifo_full=0`: 256 `wr_en` pulses, `din_dma` 0..255, `burst_count=1`, `pad_count=0`, `busy_pad` never high.
- 10 words, then a `flush_req` pulse: 246 writes of 32'hAAAA_AAAA, `pad_count=246`, `burst_count=1`, `s_ready` low for 246 cycles; an 11th word presented during padding is written as index 0 of burst 2.
- 3 words, then idle: padding starts exactly FLUSH_TIMEOUT+1 cycles after the last accept, 253 pad words, `burst_count=1`; with `word_cnt==0` and idle for 10000 cycles, no pad and no `wr_en`.
- `fifo_full` toggled every 4 cycles during PAD after 100 words: no `wr_en` in cycles following a `fifo_full=1` decision, total pad exactly 156, `burst_count=1`.
- Simultaneous events: `flush_req` in the same cycle as the 256th word is accepted → no padding; `flush_req` with `word_cnt==0` → ignored.
- `wr_aresetn` pulsed low mid-pad (after 50 pad words): all outputs return to reset values asynchronously; after release, the next 256 words form a clean burst with `burst_count=1`, `pad_count=0`.
